// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback stage.
package writeback_unit_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_THREADS    = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    // Registers below this index are hard-wired and never written.
    localparam int unsigned RO_REG_COUNT  = 4;

    typedef logic [WB_DATA_WIDTH-1:0] data_t;

    // Three bits wide so that encodings 4..7 exist and can be treated as illegal.
    typedef enum logic [2:0] {
        ALU_OUT          = 3'd0,
        LSU_OUT          = 3'd1,
        IMMEDIATE        = 3'd2,
        VECTOR_TO_SCALAR = 3'd3
    } reg_input_mux_t;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_LSU = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_t;

    // True when a request with this source and destination may write the register file.
    function automatic logic writes_regfile(input reg_input_mux_t src,
                                            input logic [REG_ADDR_W-1:0] rd);
        logic w_src_ok;
        w_src_ok = (src == ALU_OUT) || (src == LSU_OUT) || (src == IMMEDIATE);
        return w_src_ok && (rd >= REG_ADDR_W'(RO_REG_COUNT));
    endfunction

endpackage

// File: rtl/writeback_unit_wb_lane.sv
// One lane of writeback data capture and load-pending tracking.
module wb_lane
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_load_direct,
    input  logic                  i_load_lsu,
    input  logic                  i_wait,
    input  logic                  i_mask_bit,
    input  logic [DATA_WIDTH-1:0] i_direct_data,
    input  logic                  i_lsu_done,
    input  logic [DATA_WIDTH-1:0] i_lsu_data,
    output logic [DATA_WIDTH-1:0] o_data_next_c,
    output logic                  o_pending_next_c
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_pending_next;

    // Next lane data/pending: direct load, arm on LSU accept, or capture a pending load response.
    always_comb begin
        w_data_next    = r_data;
        w_pending_next = r_pending;
        if (i_enable) begin
            if (i_load_direct) begin
                w_data_next    = i_direct_data;
                w_pending_next = 1'b0;
            end else if (i_load_lsu) begin
                w_pending_next = i_mask_bit;
            end else if (i_wait && r_pending && i_lsu_done) begin
                w_data_next    = i_lsu_data;
                w_pending_next = 1'b0;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_data    <= w_data_next;
            r_pending <= w_pending_next;
        end
    end

    assign o_data_next_c    = w_data_next;
    assign o_pending_next_c = w_pending_next;

endmodule

// File: rtl/writeback_unit.sv
// Warp writeback stage: collects ALU/immediate/load results and issues one register-file write.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned THREADS_PER_WARP = WB_THREADS,
    parameter int unsigned DATA_WIDTH       = WB_DATA_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [THREADS_PER_WARP-1:0]                 in_thread_mask,
    input  logic [REG_ADDR_W-1:0]                       in_rd_address,
    input  reg_input_mux_t                              in_reg_input_mux,
    input  logic [DATA_WIDTH-1:0]                       in_immediate,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] alu_out,
    input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lsu_out,
    input  logic [THREADS_PER_WARP-1:0]                 lsu_done,
    output logic                                        wb_valid,
    output logic [THREADS_PER_WARP-1:0]                 wb_thread_enable,
    output logic [REG_ADDR_W-1:0]                       wb_rd_address,
    output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] wb_data,
    output logic                                        done
);

    wb_state_t                                   r_state;
    logic [REG_ADDR_W-1:0]                       r_rd;
    logic [THREADS_PER_WARP-1:0]                 r_mask;
    logic                                        r_write;
    logic                                        r_wb_valid;
    logic                                        r_done;
    logic [THREADS_PER_WARP-1:0]                 r_wb_thread_enable;
    logic [REG_ADDR_W-1:0]                       r_wb_rd_address;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] r_wb_data;

    logic                                        w_accept;
    logic                                        w_is_lsu;
    logic                                        w_load_direct;
    logic                                        w_load_lsu;
    logic                                        w_wait;
    logic                                        w_req_write;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] w_direct_data;
    logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] w_data_next;
    logic [THREADS_PER_WARP-1:0]                 w_pending_next;

    // Ready only when idle, enabled and out of reset, so a reset-aborted request is never accepted.
    assign in_ready      = !reset && enable && (r_state == WB_IDLE);
    assign w_accept      = in_valid && in_ready;
    assign w_is_lsu      = (in_reg_input_mux == LSU_OUT);
    assign w_load_direct = w_accept && !w_is_lsu;
    assign w_load_lsu    = w_accept && w_is_lsu;
    assign w_wait        = (r_state == WB_WAIT_LSU);
    assign w_req_write   = writes_regfile(in_reg_input_mux, in_rd_address);

    // Per-lane direct data: immediate broadcast, otherwise the lane's ALU result.
    always_comb begin
        w_direct_data = '0;
        for (int i = 0; i < int'(THREADS_PER_WARP); i++) begin
            w_direct_data[i] = (in_reg_input_mux == IMMEDIATE) ? in_immediate : alu_out[i];
        end
    end

    for (genvar g = 0; g < int'(THREADS_PER_WARP); g++) begin : g_lane
        wb_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .i_enable         (enable),
            .i_load_direct    (w_load_direct),
            .i_load_lsu       (w_load_lsu),
            .i_wait           (w_wait),
            .i_mask_bit       (in_thread_mask[g]),
            .i_direct_data    (w_direct_data[g]),
            .i_lsu_done       (lsu_done[g]),
            .i_lsu_data       (lsu_out[g]),
            .o_data_next_c    (w_data_next[g]),
            .o_pending_next_c (w_pending_next[g])
        );
    end

    // Writeback FSM with registered commit outputs; enable low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= WB_IDLE;
            r_rd               <= '0;
            r_mask             <= '0;
            r_write            <= 1'b0;
            r_wb_valid         <= 1'b0;
            r_done             <= 1'b0;
            r_wb_thread_enable <= '0;
            r_wb_rd_address    <= '0;
            r_wb_data          <= '0;
        end else if (enable) begin
            r_wb_valid         <= 1'b0;
            r_done             <= 1'b0;
            r_wb_thread_enable <= '0;
            case (r_state)
                WB_IDLE: begin
                    if (w_accept) begin
                        r_rd    <= in_rd_address;
                        r_mask  <= in_thread_mask;
                        r_write <= w_req_write;
                        if (w_is_lsu && (in_thread_mask != '0)) begin
                            r_state <= WB_WAIT_LSU;
                        end else begin
                            r_state            <= WB_COMMIT;
                            r_wb_valid         <= 1'b1;
                            r_done             <= 1'b1;
                            r_wb_rd_address    <= in_rd_address;
                            r_wb_data          <= w_data_next;
                            r_wb_thread_enable <= w_req_write ? in_thread_mask : '0;
                        end
                    end
                end
                WB_WAIT_LSU: begin
                    if (w_pending_next == '0) begin
                        r_state            <= WB_COMMIT;
                        r_wb_valid         <= 1'b1;
                        r_done             <= 1'b1;
                        r_wb_rd_address    <= r_rd;
                        r_wb_data          <= w_data_next;
                        r_wb_thread_enable <= r_write ? r_mask : '0;
                    end
                end
                WB_COMMIT: begin
                    r_state <= WB_IDLE;
                end
                default: begin
                    r_state <= WB_IDLE;
                end
            endcase
        end
    end

    assign wb_valid         = r_wb_valid;
    assign done             = r_done;
    assign wb_thread_enable = r_wb_thread_enable;
    assign wb_rd_address    = r_wb_rd_address;
    assign wb_data          = r_wb_data;

    // Flags an out-of-range source select at accept; it is handled as a no-write request.
    a_mux_legal: assert property (@(posedge clk) disable iff (reset)
        w_accept |-> (in_reg_input_mux inside {ALU_OUT, LSU_OUT, IMMEDIATE, VECTOR_TO_SCALAR}))
        else $error("writeback_unit: illegal reg_input_mux %0d", in_reg_input_mux);

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter THREADS_PER_WARP, default 32, lanes per warp.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, register data width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  warp enable; low freezes all state and outputs.
REQ-006 in_valid  input  1  writeback request from execute stage.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 in_thread_mask  input  THREADS_PER_WARP  execution mask of request.
REQ-009 in_rd_address  input  5  destination register index.
REQ-010 in_reg_input_mux  input  reg_input_mux_t  source select (ALU_OUT, LSU_OUT, IMMEDIATE, VECTOR_TO_SCALAR).
REQ-011 in_immediate  input  data_t  immediate value.
REQ-012 alu_out  input  data_t[THREADS_PER_WARP]  per-lane ALU result, valid in accept cycle.
REQ-013 lsu_out  input  data_t[THREADS_PER_WARP]  per-lane load data.
REQ-014 lsu_done  input  THREADS_PER_WARP  per-lane load-response strobe; lanes complete independently.
REQ-015 wb_valid  output  1  register-file write strobe, one cycle.
REQ-016 wb_thread_enable  output  THREADS_PER_WARP  per-lane write enable.
REQ-017 wb_rd_address  output  5  destination index.
REQ-018 wb_data  output  data_t[THREADS_PER_WARP]  per-lane write data.
REQ-019 done  output  1  one-cycle completion pulse to warp scheduler, coincident with wb_valid.

Function
REQ-020 FSM states SHALL be WB_IDLE, WB_WAIT_LSU, WB_COMMIT; in_ready = 1 only in WB_IDLE with enable high.
REQ-021 On accept with ALU_OUT or IMMEDIATE: latch rd, mask, per-lane data (alu_out[i] or in_immediate); next state WB_COMMIT.
REQ-022 On accept with LSU_OUT: latch rd and mask, pending = mask; next state WB_WAIT_LSU, or WB_COMMIT if mask is all-zero.
REQ-023 In WB_WAIT_LSU, for each lane with lsu_done[i] && pending[i]: capture lsu_out[i], clear pending[i]; lsu_done on non-pending lanes ignored.
REQ-024 WB_WAIT_LSU -> WB_COMMIT in the cycle after pending becomes zero (the cycle in which the last pending bit clears).
REQ-025 lsu_done in WB_IDLE or WB_COMMIT, or with enable low, SHALL be ignored.
REQ-026 In WB_COMMIT: wb_valid = 1, done = 1, wb_rd_address = latched rd, wb_data = latched data; next state WB_IDLE.
REQ-027 wb_thread_enable = latched mask, forced all-zero when rd < 4 (read-only registers) or source is VECTOR_TO_SCALAR; done still pulses.
REQ-028 Latency: ALU/IMMEDIATE accept at cycle N gives wb_valid at N+1; LSU last response at M gives wb_valid at M+1.
REQ-029 Outside WB_COMMIT: wb_valid = 0, done = 0, wb_thread_enable = 0; wb_data/wb_rd_address hold last value.
REQ-030 Invalid reg_input_mux value SHALL be treated as VECTOR_TO_SCALAR (no write, done pulses) and flagged by a simulation-only error.
REQ-031 enable low SHALL hold state, pending, and latched data; FSM resumes unchanged when enable returns.

Reset
REQ-032 Asserting reset at any time (including mid WB_WAIT_LSU) SHALL immediately force WB_IDLE, pending = 0, latched data/rd/mask = 0, all outputs 0 except in_ready, which becomes 1 once reset deasserts with enable high.
REQ-033 No wb_valid or done SHALL be emitted for a request aborted by reset.

Structure
REQ-034 wb_state_t (WB_IDLE, WB_WAIT_LSU, WB_COMMIT) SHALL be added to the shared package alongside data_t and reg_input_mux_t.
REQ-035 Per-lane capture/pending logic SHALL be one sub-module, wb_lane, instantiated THREADS_PER_WARP times.

Verification
REQ-036 ALU: mask 0xFFFFFFFF, rd=5, alu_out[i]=i*3 accepted at cycle 10 -> wb_valid, done at 11, wb_data[i]=i*3, wb_thread_enable all ones.
REQ-037 LSU out-of-order: mask 0x0000000F, rd=7; lsu_done lanes 3,1,0,2 on consecutive cycles with data 0xA0+i -> single wb_valid the cycle after lane 2, enable 0xF, wb_data[i]=0xA0+i; in_ready low throughout.
REQ-038 Read-only: IMMEDIATE 0x1234, rd=2 -> done pulses, wb_thread_enable = 0.
REQ-039 Empty mask LSU request -> wb_valid one cycle after accept, enables 0; stray lsu_done ignored.
REQ-040 Reset asserted mid WB_WAIT_LSU with 2 lanes pending -> outputs 0 immediately, no done, subsequent ALU request completes normally.
REQ-041 enable low for 3 cycles during WB_WAIT_LSU with lsu_done toggling -> responses ignored, completion only after remaining responses arrive with enable high.
